// File: rtl/nested_loop_pkg.sv
// ============================================================================
//  nested_loop_pkg
//  Shared state encoding and default width for the nested loop sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package nested_loop_pkg;

    localparam int W_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nested_loop_index_ctr.sv
// ============================================================================
//  nested_loop_index_ctr
//  Outer/inner index registers with captured limits, step, wrap and last flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module nested_loop_index_ctr
    import nested_loop_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] load_outer,
    input  logic [W-1:0] load_inner,
    output logic [W-1:0] idx_i,
    output logic [W-1:0] idx_j,
    output logic         last
);

    logic [W-1:0] i_q, i_d;
    logic [W-1:0] j_q, j_d;
    logic [W-1:0] outer_q, outer_d;
    logic [W-1:0] inner_q, inner_d;

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        outer_d = outer_q;
        inner_d = inner_q;
        if (load) begin
            outer_d = load_outer;
            inner_d = load_inner;
            i_d     = '0;
            j_d     = W'(1);
        end else if (step) begin
            if (j_q < inner_q) begin
                j_d = j_q + W'(1);
            end else begin
                j_d = W'(1);
                i_d = i_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q     <= '0;
            j_q     <= '0;
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

    // Only meaningful while running, where both limits are known to be non-zero.
    assign last  = (i_q == outer_q - W'(1)) && (j_q == inner_q);
    assign idx_i = i_q;
    assign idx_j = j_q;

endmodule

`default_nettype wire

// File: rtl/nested_loop_sequencer.sv
// ============================================================================
//  nested_loop_sequencer
//  Walks (i, j) over a two-level loop nest, one pair per accepted beat, and
//  reports the emitted-pair count with a done pulse. Skip of the (SKIP_I,
//  SKIP_J) pair is enabled by defining NESTED_LOOP_SKIP_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module nested_loop_sequencer
    import nested_loop_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int SKIP_I = 1,
    parameter int SKIP_J = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_outer_limit,
    input  logic [W-1:0]   in_inner_limit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_i,
    output logic [W-1:0]   out_j,
    output logic           out_done,
    output logic [2*W-1:0] out_count
);

    state_t         state_q, state_d;
    logic [2*W-1:0] count_q, count_d;
    logic           accept;
    logic           skip;
    logic           beat;
    logic           step;
    logic           last;
    logic [W-1:0]   idx_i;
    logic [W-1:0]   idx_j;

    assign accept = (state_q == IDLE) && in_valid;

`ifdef NESTED_LOOP_SKIP_EN
    assign skip = (idx_i == W'(SKIP_I)) && (idx_j == W'(SKIP_J));
`else
    // Skip parameters stay in the interface but never match anything.
    assign skip = ((SKIP_I & 0) | (SKIP_J & 0)) != 0;
`endif

    assign out_valid = (state_q == RUN) && !skip;
    assign beat      = out_valid && out_ready;
    // A skipped pair advances on its own after its single bubble cycle.
    assign step      = (state_q == RUN) && (skip || out_ready);

    nested_loop_index_ctr #(
        .W (W)
    ) u_index_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .load_outer (in_outer_limit),
        .load_inner (in_inner_limit),
        .idx_i      (idx_i),
        .idx_j      (idx_j),
        .last       (last)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    count_d = '0;
                    if ((in_outer_limit == '0) || (in_inner_limit == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    count_d = count_q + (2*W)'(1);
                end
                if (step && last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_done  = (state_q == DONE);
    assign out_count = count_q;
    assign out_i     = idx_i;
    assign out_j     = idx_j;

endmodule

`default_nettype wire
